// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared defaults and divisor types for the UART baud generator.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DEF_DIV_INT    = 5;
  localparam int DEF_DIV_FRAC   = 0;
  localparam int OVERSAMPLE_DEF = 8;
  localparam int DIV_W_DEF      = 16;
  localparam int FRAC_W_DEF     = 8;

  typedef logic [DIV_W_DEF-1:0]  div_int_t;
  typedef logic [FRAC_W_DEF-1:0] div_frac_t;

  typedef struct packed {
    div_int_t  d_int;
    div_frac_t d_frac;
  } divisor_t;

endpackage
`default_nettype wire

// File: rtl/frac_div_core.sv
`default_nettype none
// ============================================================================
// Module   : frac_div_core
// Brief    : Fractional period counter; emits a registered RX tick per period.
// Revision : 1.0 - initial release
// ============================================================================
module frac_div_core
  import uart_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              resync,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              period_end,
  output logic              tick_rx
);

  logic [DIV_W:0]  r_cnt;
  logic            r_ext;
  logic [FRAC_W-1:0] r_acc;
  logic            r_tick;

  logic [DIV_W:0]  w_int_eff;
  logic [DIV_W:0]  w_period;
  logic [FRAC_W:0] w_acc_sum;

  // Divisors 0 and 1 both collapse to a one-cycle period.
  always_comb begin
    w_int_eff  = (div_int < DIV_W'(2)) ? (DIV_W+1)'(1) : {1'b0, div_int};
    w_period   = w_int_eff + {{DIV_W{1'b0}}, r_ext};
    w_acc_sum  = {1'b0, r_acc} + {1'b0, div_frac};
    // >= rather than == so a divisor shrunk while stopped still ends the period.
    period_end = enable & ~resync & (r_cnt >= w_period);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= (DIV_W+1)'(1);
      r_ext  <= 1'b0;
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else if (resync) begin
      r_cnt  <= (DIV_W+1)'(1);
      r_ext  <= 1'b0;
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else if (!enable) begin
      r_tick <= 1'b0;
    end else if (period_end) begin
      r_cnt  <= (DIV_W+1)'(1);
      r_acc  <= w_acc_sum[FRAC_W-1:0];
      r_ext  <= w_acc_sum[FRAC_W];
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + (DIV_W+1)'(1);
      r_tick <= 1'b0;
    end
  end

  assign tick_rx = r_tick;

endmodule
`default_nettype wire

// File: rtl/baud_gen_frac.sv
`default_nettype none
// ============================================================================
// Module   : baud_gen_frac
// Brief    : Fractional UART baud generator with oversampled RX and bit-rate TX ticks.
// Revision : 1.0 - initial release
// ============================================================================
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int DIV_W      = DIV_W_DEF,
  parameter int FRAC_W     = FRAC_W_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              div_int,
  input  logic [FRAC_W-1:0]             div_frac,
  input  logic                          div_load,
  input  logic                          resync,
  output logic                          baud_tick_rx,
  output logic                          baud_tick_tx,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] c_os_last = OS_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0]  r_sh_int;
  logic [FRAC_W-1:0] r_sh_frac;
  logic [DIV_W-1:0]  r_act_int;
  logic [FRAC_W-1:0] r_act_frac;
  logic              r_pend;
  logic [OS_W-1:0]   r_os;
  logic              r_tx;

  logic              w_period_end;
  logic              w_xfer;
  logic [OS_W-1:0]   w_os_next;

  // A pending divisor only swaps in at a period boundary, or at once when stopped.
  always_comb begin
    w_xfer    = r_pend & (w_period_end | ~enable);
    w_os_next = (r_os == c_os_last) ? '0 : r_os + OS_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh_int   <= DIV_W'(DEF_DIV_INT);
      r_sh_frac  <= FRAC_W'(DEF_DIV_FRAC);
      r_act_int  <= DIV_W'(DEF_DIV_INT);
      r_act_frac <= FRAC_W'(DEF_DIV_FRAC);
      r_pend     <= 1'b0;
    end else begin
      if (div_load) begin
        r_sh_int  <= div_int;
        r_sh_frac <= div_frac;
      end
      if (resync && div_load) begin
        r_act_int  <= div_int;
        r_act_frac <= div_frac;
        r_pend     <= 1'b0;
      end else begin
        if (w_xfer) begin
          r_act_int  <= r_sh_int;
          r_act_frac <= r_sh_frac;
        end
        r_pend <= div_load | (r_pend & ~w_xfer);
      end
    end
  end

  frac_div_core #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_core (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .resync     (resync),
    .div_int    (r_act_int),
    .div_frac   (r_act_frac),
    .period_end (w_period_end),
    .tick_rx    (baud_tick_rx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_os <= '0;
      r_tx <= 1'b0;
    end else if (resync) begin
      r_os <= '0;
      r_tx <= 1'b0;
    end else if (w_period_end) begin
      r_os <= w_os_next;
      r_tx <= (w_os_next == c_os_last);
    end else begin
      r_tx <= 1'b0;
    end
  end

  assign baud_tick_tx = r_tx;
  assign os_phase     = r_os;

endmodule
`default_nettype wire

// File: tb/tb_baud_gen_frac.sv
`default_nettype none
// ============================================================================
// Module   : tb_baud_gen_frac
// Brief    : Self-checking bench for baud_gen_frac against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_baud_gen_frac;
  import uart_pkg::*;

  localparam int DIV_W      = 16;
  localparam int FRAC_W     = 8;
  localparam int OVERSAMPLE = 8;
  localparam int OS_W       = 3;
  localparam int FRAC_MOD   = 1 << FRAC_W;

  logic              clk      = 1'b0;
  logic              reset_n  = 1'b1;
  logic              enable   = 1'b0;
  logic [DIV_W-1:0]  div_int  = '0;
  logic [FRAC_W-1:0] div_frac = '0;
  logic              div_load = 1'b0;
  logic              resync   = 1'b0;
  logic              baud_tick_rx;
  logic              baud_tick_tx;
  logic [OS_W-1:0]   os_phase;

  baud_gen_frac #(
    .DIV_W      (DIV_W),
    .FRAC_W     (FRAC_W),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .div_int      (div_int),
    .div_frac     (div_frac),
    .div_load     (div_load),
    .resync       (resync),
    .baud_tick_rx (baud_tick_rx),
    .baud_tick_tx (baud_tick_tx),
    .os_phase     (os_phase)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: enabled cycles elapsed in the period versus its length.
  int m_int     = DEF_DIV_INT;
  int m_frac    = DEF_DIV_FRAC;
  int s_int     = DEF_DIV_INT;
  int s_frac    = DEF_DIV_FRAC;
  int m_elapsed = 0;
  int m_ext     = 0;
  int m_acc     = 0;
  int m_ntick   = 0;
  int m_per;
  bit m_pend    = 1'b0;
  bit m_fire;
  bit m_xfer;
  bit e_rx      = 1'b0;
  bit e_tx      = 1'b0;
  int e_os      = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_int = DEF_DIV_INT;  m_frac = DEF_DIV_FRAC;
      s_int = DEF_DIV_INT;  s_frac = DEF_DIV_FRAC;
      m_pend = 1'b0; m_elapsed = 0; m_ext = 0; m_acc = 0; m_ntick = 0;
      e_rx = 1'b0; e_tx = 1'b0; e_os = 0;
    end else begin
      e_rx = 1'b0;
      e_tx = 1'b0;
      if (resync && div_load) begin
        m_int = int'(div_int);  m_frac = int'(div_frac);
        s_int = int'(div_int);  s_frac = int'(div_frac);
        m_pend = 1'b0; m_elapsed = 0; m_ext = 0; m_acc = 0; m_ntick = 0; e_os = 0;
      end else begin
        m_fire = 1'b0;
        if (!resync && enable) begin
          m_per = ((m_int < 2) ? 1 : m_int) + m_ext;
          m_elapsed++;
          m_fire = (m_elapsed >= m_per);
        end
        m_xfer = m_pend && (m_fire || !enable);
        if (resync) begin
          m_elapsed = 0; m_ext = 0; m_acc = 0; m_ntick = 0; e_os = 0;
        end else if (m_fire) begin
          m_acc     = m_acc + m_frac;
          m_ext     = m_acc / FRAC_MOD;
          m_acc     = m_acc % FRAC_MOD;
          m_elapsed = 0;
          m_ntick++;
          e_rx = 1'b1;
          e_os = m_ntick % OVERSAMPLE;
          e_tx = (e_os == OVERSAMPLE - 1);
        end
        if (m_xfer) begin
          m_int = s_int; m_frac = s_frac; m_pend = 1'b0;
        end
        if (div_load) begin
          s_int = int'(div_int); s_frac = int'(div_frac); m_pend = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("rx_tick",  int'(baud_tick_rx), int'(e_rx));
      check("tx_tick",  int'(baud_tick_tx), int'(e_tx));
      check("os_phase", int'(os_phase),     e_os);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int max, output int n);
    n = 0;
    while (n < max) begin
      step();
      n++;
      if (baud_tick_rx) return;
    end
    n = -1;
  endtask

  task automatic wait_tx(input int max, output int n);
    n = 0;
    while (n < max) begin
      step();
      n++;
      if (baud_tick_tx) return;
    end
    n = -1;
  endtask

  task automatic reload(input int di, input int df);
    div_int  = DIV_W'(di);
    div_frac = FRAC_W'(df);
    div_load = 1'b1;
    resync   = 1'b1;
    step();
    div_load = 1'b0;
    resync   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;
    int seen;

    #2 reset_n = 1'b0;
    chk_on = 1'b1;
    #1;
    check("reset_rx", int'(baud_tick_rx), 0);
    check("reset_tx", int'(baud_tick_tx), 0);
    check("reset_os", int'(os_phase), 0);
    repeat (3) step();
    enable  = 1'b1;
    reset_n = 1'b1;

    // Default divisor 5, oversample 8.
    wait_rx(50, n);  check("first_tick_latency", n, 5);
    wait_rx(50, n);  check("default_period", n, 5);
    wait_tx(400, n); check("tx_os_phase", int'(os_phase), 7);
    check("tx_with_rx", int'(baud_tick_rx), 1);
    wait_tx(400, n); check("tx_period", n, 40);

    // 5 + 0.5: periods settle into 5,6 alternation.
    reload(5, 'h80);
    wait_rx(50, n);  check("frac_first", n, 5);
    t = 0;
    for (int i = 0; i < 200; i++) begin
      wait_rx(50, n);
      t += n;
    end
    check("frac_200_ticks", t, 1100);
    wait_rx(50, n);  check("frac_short", n, 5);
    wait_rx(50, n);  check("frac_long", n, 6);

    // Load mid-period: current period still runs to 5.
    reload(5, 0);
    wait_rx(50, n);
    step();
    div_int  = DIV_W'(3);
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    wait_rx(50, n);  check("load_current_period", n, 3);
    wait_rx(50, n);  check("load_new_period", n, 3);

    // Divisors 0 and 1 tick every cycle.
    reload(0, 0);
    wait_rx(50, n);  check("div0_first", n, 1);
    wait_rx(50, n);  check("div0_period", n, 1);
    reload(1, 0);
    wait_rx(50, n);  check("div1_period", n, 1);

    // Resync at count 4.
    reload(5, 0);
    wait_rx(50, n);
    repeat (3) step();
    resync = 1'b1;
    step();
    resync = 1'b0;
    check("resync_os_phase", int'(os_phase), 0);
    check("resync_no_tick", int'(baud_tick_rx), 0);
    wait_rx(50, n);  check("resync_next_tick", n, 5);

    // Enable low for 7 cycles after 2 enabled cycles.
    wait_rx(50, n);
    repeat (2) step();
    enable = 1'b0;
    seen = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (baud_tick_rx || baud_tick_tx) seen++;
    end
    check("enable_low_no_tick", seen, 0);
    enable = 1'b1;
    wait_rx(50, n);  check("enable_resume", n, 3);

    // Asynchronous reset at count 3 of a 7-period; defaults come back.
    reload(7, 0);
    wait_rx(50, n);
    repeat (2) step();
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_rx", int'(baud_tick_rx), 0);
    check("async_reset_os", int'(os_phase), 0);
    step();
    reset_n = 1'b1;
    wait_rx(50, n);  check("reset_first_tick", n, 5);

    // Randomized traffic, checked every cycle by the model compare.
    for (int c = 0; c < 4000; c++) begin
      enable   = ($urandom_range(0, 7) != 0);
      div_load = ($urandom_range(0, 15) == 0);
      resync   = ($urandom_range(0, 31) == 0);
      div_int  = DIV_W'($urandom_range(0, 9));
      div_frac = FRAC_W'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #1 reset_n = 1'b0;
      end
      step();
      reset_n = 1'b1;
    end
    div_load = 1'b0;
    resync   = 1'b0;
    enable   = 1'b1;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 Parameter DIV_W, default 16, width of the integer divisor.
REQ-002 Parameter FRAC_W, default 8, width of the fractional divisor.
REQ-003 Parameter OVERSAMPLE, default 8, RX ticks per TX tick; SHALL be at least 2.
REQ-004 Port clk, input, 1 bit, sole clock; all state SHALL update on its rising edge.
REQ-005 Port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 Port enable, input, 1 bit, run/stop of the divider.
REQ-007 Port div_int, input, DIV_W bits, integer clocks per RX tick.
REQ-008 Port div_frac, input, FRAC_W bits, fractional clocks per RX tick, in units of 2^-FRAC_W.
REQ-009 Port div_load, input, 1 bit, single-cycle strobe that captures div_int and div_frac into a shadow register.
REQ-010 Port resync, input, 1 bit, single-cycle strobe that restarts the period and oversample phase.
REQ-011 Port baud_tick_rx, output, 1 bit, one-cycle pulse at the oversampled rate.
REQ-012 Port baud_tick_tx, output, 1 bit, one-cycle pulse at the bit rate.
REQ-013 Port os_phase, output, $clog2(OVERSAMPLE) bits, index of the current RX tick within the bit.

Function
REQ-014 Active divisor SHALL be (D_int + D_frac/2^FRAC_W); D_int values 0 and 1 SHALL both give a tick every cycle.
REQ-015 The period counter SHALL count 1..P and assert baud_tick_rx on the cycle it equals P, then restart at 1.
  - P is D_int plus the current fractional extension (0 or 1).
REQ-016 The fractional accumulator (FRAC_W bits) SHALL add D_frac on every baud_tick_rx.
  - Carry-out SHALL set the extension to 1 for the next period only.
  - Accumulation SHALL wrap modulo 2^FRAC_W.
REQ-017 os_phase SHALL increment on each baud_tick_rx and wrap from OVERSAMPLE-1 to 0.
REQ-018 baud_tick_tx SHALL assert in the same cycle as the baud_tick_rx on which os_phase is OVERSAMPLE-1.
REQ-019 div_load SHALL write the shadow register in the cycle it is sampled.
  - Shadow to active transfer SHALL happen on the next baud_tick_rx, so no period is truncated.
  - When enable is low, the transfer SHALL happen in the cycle after div_load.
REQ-020 resync SHALL clear the period counter to 1, os_phase to 0, the accumulator and the extension.
  - It SHALL suppress any tick in that cycle.
  - The next baud_tick_rx SHALL occur D_int cycles later.
REQ-021 resync SHALL take priority over a simultaneous period-end.
  - resync and div_load in the same cycle SHALL load the shadow and apply it immediately.
REQ-022 With enable low, the counter, os_phase and accumulator SHALL hold and both tick outputs SHALL be 0.
  - Counting SHALL resume from the held value on re-enable.
REQ-023 Both tick outputs SHALL be registered; each pulse SHALL be exactly one cycle wide, with no glitches.

Reset
REQ-024 While reset_n is low, all outputs SHALL be 0.
  - Counter = 1, os_phase = 0, accumulator = 0.
  - Shadow and active divisor SHALL take the package defaults.
REQ-025 The first baud_tick_rx after release SHALL occur D_int cycles after the first enabled rising edge.
REQ-026 Reset asserted mid-period SHALL abort it immediately, with no residual tick.

Structure
REQ-027 Package uart_pkg SHALL hold the defaults: DEF_DIV_INT = 5 and DEF_DIV_FRAC = 0.
  - The package SHALL also hold OVERSAMPLE_DEF = 8 and the divisor typedefs.
REQ-028 The period counter and fractional accumulator SHALL be one sub-module, frac_div_core, emitting the RX tick.
  - The top level SHALL hold the shadow register, os_phase and TX tick logic.

Verification
REQ-029 div_int=5, div_frac=0, OVERSAMPLE=8, enable=1 -> baud_tick_rx every 5 clocks; baud_tick_tx every 40 clocks, coincident with os_phase=7.
REQ-030 FRAC_W=8, div_int=5, div_frac=0x80 -> RX periods alternate 5,6; exactly 1100 clocks per 200 RX ticks.
REQ-031 div_load with div_int=3 issued at count 2 of a 5-period -> current period completes at 5; following periods are 3.
REQ-032 resync pulsed at count 4 with div_int=5 -> no tick at count 5; next baud_tick_rx 5 cycles after resync; os_phase=0.
REQ-033 enable low for 7 cycles mid-period -> no ticks while low; period completes with exactly 5 enabled cycles total.
REQ-034 reset_n low for 1 cycle asynchronously at count 3 -> outputs 0 immediately; first tick 5 enabled cycles after release.
